// File: rtl/dmem_copy_engine_pkg.sv
// Shared definitions for the data-memory copy/fill engine.
//   state_t      : engine FSM states
//   *_W_DEF      : default widths for address, data and transfer length
package dmem_copy_engine_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LEN_W_DEF  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_copy_engine.sv
// Data-memory copy/fill engine. Moves len words from src to dst (copy) or
// writes a constant pattern to dst (fill) through a single-port memory
// interface, in strictly ascending word order, and reports a mod-2^DATA_W
// checksum of the words written.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request pulse, honoured only while idle
//   fill         : 0 = copy src->dst, 1 = write pattern to dst
//   src, dst     : base addresses (latched at start)
//   len          : word count (latched at start, clamped to memory depth)
//   pattern      : fill value (latched at start)
//   E, WE, Addr, DI : memory enable, write enable, address, write data
//   DO           : memory read data, combinational from Addr
//   busy, done   : transfer in progress / one-cycle completion pulse
//   sum          : checksum of the words written by the last transfer
module dmem_copy_engine
  import dmem_copy_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] pattern,
  output logic              E,
  output logic              WE,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] DI,
  input  logic [DATA_W-1:0] DO,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum
);

  // Transfers longer than the memory would revisit words; cap at the depth.
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t            state_q, state_nx;
  logic              fill_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, i_q, i_nx, i_inc, len_clamped;
  logic [DATA_W-1:0] pattern_q;

  logic              e_nx, we_nx, busy_nx, done_nx, load;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] di_nx, sum_nx;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign i_inc       = i_q + LEN_W'(1);

  // Outputs are registered: each branch sets up the memory cycle that the
  // *next* state will present, so E/WE/Addr/DI line up with state_q.
  always_comb begin
    state_nx = state_q;
    e_nx     = 1'b0;
    we_nx    = 1'b0;
    addr_nx  = Addr;   // held while the memory is disabled
    di_nx    = DI;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    i_nx     = i_q;
    sum_nx   = sum;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load   = 1'b1;
          i_nx   = '0;
          sum_nx = '0;
          if (len_clamped == '0) begin
            state_nx = ST_DONE;
            done_nx  = 1'b1;
          end else if (fill) begin
            state_nx = ST_WRITE;
            e_nx     = 1'b1;
            we_nx    = 1'b1;
            addr_nx  = dst;
            di_nx    = pattern;
            busy_nx  = 1'b1;
          end else begin
            state_nx = ST_READ;
            e_nx     = 1'b1;
            addr_nx  = src;
            busy_nx  = 1'b1;
          end
        end
      end
      ST_READ: begin
        // DO is valid for the read address now; it becomes the write data.
        state_nx = ST_WRITE;
        e_nx     = 1'b1;
        we_nx    = 1'b1;
        addr_nx  = dst_q + i_q[ADDR_W-1:0];
        di_nx    = DO;
        busy_nx  = 1'b1;
      end
      ST_WRITE: begin
        sum_nx = sum + DI;
        i_nx   = i_inc;
        if (i_inc < len_q) begin
          e_nx    = 1'b1;
          busy_nx = 1'b1;
          if (fill_q) begin
            state_nx = ST_WRITE;
            we_nx    = 1'b1;
            addr_nx  = dst_q + i_inc[ADDR_W-1:0];
            di_nx    = pattern_q;
          end else begin
            state_nx = ST_READ;
            addr_nx  = src_q + i_inc[ADDR_W-1:0];
          end
        end else begin
          state_nx = ST_DONE;
          done_nx  = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      E       <= 1'b0;
      WE      <= 1'b0;
      Addr    <= '0;
      DI      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_nx;
      E       <= e_nx;
      WE      <= we_nx;
      Addr    <= addr_nx;
      DI      <= di_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      sum     <= sum_nx;
      i_q     <= i_nx;
    end
  end

  // Transfer operands: pure data, captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (load) begin
      fill_q    <= fill;
      src_q     <= src;
      dst_q     <= dst;
      len_q     <= len_clamped;
      pattern_q <= pattern;
    end
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: attaches a 16x8 data memory and compares
// results against a word-by-word reference of the transfer rules.
module tb_dmem_copy_engine;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          fill = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] pattern = '0;
  logic          E, WE, busy, done;
  logic [AW-1:0] Addr;
  logic [DW-1:0] DI, DO, sum;

  always #5 clk = ~clk;

  dmem_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fill(fill), .src(src),
    .dst(dst), .len(len), .pattern(pattern), .E(E), .WE(WE), .Addr(Addr),
    .DI(DI), .DO(DO), .busy(busy), .done(done), .sum(sum)
  );

  // 16x8 data memory
  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic [7:0] refm[16];
  logic       ld_all = 1'b0;

  always @(posedge clk) begin
    if (ld_all) mem <= img;
    else if (E && WE) mem[Addr] <= DI;
  end
  assign DO = E ? mem[Addr] : 8'h00;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_img();
    @(negedge clk);
    ld_all = 1'b1;
    @(posedge clk);
    #1 ld_all = 1'b0;
    for (int k = 0; k < 16; k++) refm[k] = img[k];
  endtask

  task automatic chk_mem(input string tag);
    for (int k = 0; k < 16; k++) chk($sformatf("%s_mem%0d", tag, k), 32'(mem[k]), 32'(refm[k]));
  endtask

  // One transfer: reference result computed word by word, then the DUT run
  // is timed and its memory traffic, flags and checksum compared.
  task automatic run(input string tag, input bit f, input int s, input int d,
                     input int l, input int p, input bit ghost);
    int n, exp_cyc, cyc, ecnt, wcnt, bbad, webad, lasta;
    logic [7:0] es, v, lastv;
    n = (l > 16) ? 16 : l;
    es = 8'h00; lastv = 8'h00; lasta = 0;
    for (int k = 0; k < n; k++) begin
      v = f ? p[7:0] : refm[(s + k) % 16];
      lasta = (d + k) % 16;
      refm[lasta] = v;
      es = es + v;
      lastv = v;
    end
    exp_cyc = f ? n + 1 : 2 * n + 1;

    @(negedge clk);
    start = 1'b1; fill = f; src = AW'(s); dst = AW'(d); len = LW'(l); pattern = DW'(p);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1; ecnt = 0; wcnt = 0; bbad = 0; webad = 0;
    while (!done && cyc < 100) begin
      if (E) ecnt++;
      if (E && WE) wcnt++;
      if (!busy) bbad++;
      if (WE && !E) webad++;
      if (ghost && (cyc == 2 || cyc == 4)) begin
        start = 1'b1; fill = 1'b1; len = LW'(1); dst = '0; pattern = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_E_at_done"}, 32'(E), 32'd0);
    chk({tag, "_writes"}, 32'(wcnt), 32'(n));
    chk({tag, "_enable_cycles"}, 32'(ecnt), 32'(f ? n : 2 * n));
    chk({tag, "_busy_gaps"}, 32'(bbad), 32'd0);
    chk({tag, "_we_without_e"}, 32'(webad), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    if (n > 0) begin
      chk({tag, "_addr_held"}, 32'(Addr), 32'(lasta));
      chk({tag, "_di_held"}, 32'(DI), 32'(lastv));
    end
    @(posedge clk);
    #1 chk({tag, "_done_single"}, 32'(done), 32'd0);
    @(posedge clk);
    #1 chk({tag, "_sum_stable"}, 32'(sum), 32'(es));
    chk_mem(tag);
  endtask

  initial begin
    int donecnt;
    for (int k = 0; k < 16; k++) img[k] = 8'(8'hC0 + k);

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_E", 32'(E), 32'd0);
    chk("rst_WE", 32'(WE), 32'd0);
    chk("rst_Addr", 32'(Addr), 32'd0);
    chk("rst_DI", 32'(DI), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Basic copy
    img[2] = 8'h11; img[3] = 8'h22; img[4] = 8'h33; img[5] = 8'h44;
    load_img();
    run("copy", 1'b0, 2, 8, 4, 0, 1'b0);
    chk("copy_sum_const", 32'(sum), 32'hAA);

    // Starts while busy are ignored
    load_img();
    run("ghost", 1'b0, 2, 8, 4, 0, 1'b1);
    chk("ghost_sum_const", 32'(sum), 32'hAA);

    // Fill wrapping past address 15
    run("fillwrap", 1'b1, 0, 14, 4, 8'h5A, 1'b0);
    chk("fillwrap_sum_const", 32'(sum), 32'h68);

    // Zero length and clamped length
    run("len0", 1'b0, 3, 7, 0, 0, 1'b0);
    run("len20fill", 1'b1, 0, 5, 20, 8'h3C, 1'b0);
    load_img();
    run("len20copy", 1'b0, 9, 9, 20, 0, 1'b0);

    // Overlapping forward copy
    img[0] = 8'd1; img[1] = 8'd2; img[2] = 8'd3; img[3] = 8'd4;
    load_img();
    run("overlap", 1'b0, 0, 1, 3, 0, 1'b0);
    chk("overlap_m1", 32'(mem[1]), 32'd1);
    chk("overlap_m3", 32'(mem[3]), 32'd1);

    // Reset during the second write of a copy
    img[2] = 8'h11; img[3] = 8'h22; img[4] = 8'h33; img[5] = 8'h44;
    load_img();
    @(negedge clk);
    start = 1'b1; fill = 1'b0; src = 4'd2; dst = 4'd8; len = 5'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("midrst_in_write", 32'(WE), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_E", 32'(E), 32'd0);
    chk("midrst_WE", 32'(WE), 32'd0);
    chk("midrst_Addr", 32'(Addr), 32'd0);
    chk("midrst_DI", 32'(DI), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    donecnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 if (done) donecnt++;
    end
    chk("midrst_no_done", 32'(donecnt), 32'd0);
    refm[8] = 8'h11;
    chk_mem("midrst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    run("after_rst", 1'b0, 2, 8, 4, 0, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
      load_img();
      run($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 20)),
          int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
